// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store controller sitting between execute and data memory.
// It computes the effective address and checks the access before touching memory.
// It runs a req/ack handshake with a bounded wait, then extends load data or lane-positions store data.
// It returns exactly one response per accepted request.
// Optional feature macro: LSU_RMW_EN. It turns sub-word stores into a read-modify-write
// sequence for memories without byte strobes.
module lsu_ctrl #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [XLEN-1:0]   req_base,
  input  logic [XLEN-1:0]   req_imm,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_data,
  output logic [1:0]        rsp_err,
  output logic              rf_wr_en
);

  localparam int SW = XLEN / 8;
  localparam int OW = $clog2(SW);
  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_MIS = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;
  localparam logic [1:0] ERR_ILL = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

`ifdef LSU_RMW_EN
  localparam logic [1:0] FULL_SZ = (XLEN == 64) ? SZ_D : SZ_W;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MEM  = 3'd1,
    S_RESP = 3'd2
`ifdef LSU_RMW_EN
    ,
    S_RD   = 3'd3,
    S_WR   = 3'd4
`endif
  } state_t;

  state_t state_q, state_d;

  // Request-side decode results (valid in the accept cycle)
  logic [1:0]      dec_size;
  logic            dec_signed;
  logic            dec_store;
  logic            dec_illegal;
  logic            dec_misaligned;
  logic [1:0]      dec_err;
  logic [XLEN-1:0] ea_next;
  logic [XLEN-1:0] wdata_rep;
  logic [31:0]     nbytes_mask;
  logic [SW-1:0]   size_mask;
  logic [SW-1:0]   wstrb_next;
  logic            accept;

  // Registered transaction context
  logic [XLEN-1:0] ea_q;
  logic [1:0]      size_q;
  logic            signed_q;
  logic            store_q;
  logic [XLEN-1:0] wdata_q;
  logic [SW-1:0]   wstrb_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rsp_data_q;
  logic [1:0]      rsp_err_q;

  // Load extraction
  logic [XLEN-1:0] lane_shift;
  logic [XLEN-1:0] ext_mask;
  logic            ext_sign;
  logic [XLEN-1:0] load_ext;

  assign accept  = req_valid && req_ready;
  assign ea_next = req_base + req_imm;

  // Classify the incoming op into size, signedness and direction, flagging illegal encodings
  always_comb begin
    dec_store   = req_op[3];
    dec_size    = SZ_B;
    dec_signed  = 1'b0;
    dec_illegal = 1'b0;
    case (req_op)
      4'd0:  begin dec_size = SZ_B; dec_signed = 1'b1; end
      4'd1:  begin dec_size = SZ_H; dec_signed = 1'b1; end
      4'd2:  begin dec_size = SZ_W; dec_signed = 1'b1; end
      4'd3:  dec_size = SZ_B;
      4'd4:  dec_size = SZ_H;
      4'd5:  begin dec_size = SZ_D; dec_signed = 1'b1; end
      4'd6:  dec_size = SZ_W;
      4'd8:  dec_size = SZ_B;
      4'd9:  dec_size = SZ_H;
      4'd10: dec_size = SZ_W;
      4'd11: dec_size = SZ_D;
      default: dec_illegal = 1'b1;
    endcase
    if ((XLEN == 32) && ((dec_size == SZ_D) || (req_op == 4'd6))) begin
      dec_illegal = 1'b1;
    end
  end

  // Alignment check and error priority: illegal op wins over misalignment
  always_comb begin
    dec_misaligned = 1'b0;
    case (dec_size)
      SZ_H:    dec_misaligned = ea_next[0];
      SZ_W:    dec_misaligned = |ea_next[1:0];
      SZ_D:    dec_misaligned = |ea_next[2:0];
      default: dec_misaligned = 1'b0;
    endcase
    dec_err = ERR_OK;
    if (dec_illegal) begin
      dec_err = ERR_ILL;
    end else if (dec_misaligned) begin
      dec_err = ERR_MIS;
    end
  end

  // Replicate store data onto every lane of its size and build the byte-lane strobe
  always_comb begin
    case (dec_size)
      SZ_B:    wdata_rep = {SW{req_wdata[7:0]}};
      SZ_H:    wdata_rep = {(SW/2){req_wdata[15:0]}};
      SZ_W:    wdata_rep = {(XLEN/32){req_wdata[31:0]}};
      default: wdata_rep = req_wdata;
    endcase
    nbytes_mask = (32'd1 << (32'd1 << dec_size)) - 32'd1;
    size_mask   = nbytes_mask[SW-1:0];
    wstrb_next  = size_mask << ea_next[OW-1:0];
  end

  // Shift the addressed lane down and sign- or zero-extend it to the full width
  always_comb begin
    lane_shift = mem_rdata >> {ea_q[OW-1:0], 3'b000};
    ext_mask   = '1;
    ext_sign   = 1'b0;
    case (size_q)
      SZ_B: begin ext_mask = XLEN'(8'hFF);         ext_sign = lane_shift[7];  end
      SZ_H: begin ext_mask = XLEN'(16'hFFFF);      ext_sign = lane_shift[15]; end
      SZ_W: begin ext_mask = XLEN'(32'hFFFF_FFFF); ext_sign = lane_shift[31]; end
      default: ;
    endcase
    load_ext = (lane_shift & ext_mask) | ((signed_q && ext_sign) ? ~ext_mask : '0);
  end

`ifdef LSU_RMW_EN
  logic [XLEN-1:0] byte_mask;
  logic [XLEN-1:0] merged;

  // Merge the new store bytes into the old word returned by the read phase
  always_comb begin
    byte_mask = '0;
    for (int i = 0; i < SW; i++) begin
      byte_mask[i*8 +: 8] = {8{wstrb_q[i]}};
    end
    merged = (mem_rdata & ~byte_mask) | (wdata_q & byte_mask);
  end
`endif

  // State register; reset drops any in-flight access immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (dec_err != ERR_OK) begin
            state_d = S_RESP;
`ifdef LSU_RMW_EN
          end else if (dec_store && (dec_size != FULL_SZ)) begin
            state_d = S_RD;
`endif
          end else begin
            state_d = S_MEM;
          end
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = store_q;
        if (mem_ack || (cnt_q == CW'(MAX_WAIT - 1))) begin
          state_d = S_RESP;
        end
      end
`ifdef LSU_RMW_EN
      S_RD: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          state_d = S_WR;
        end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
          state_d = S_RESP;
        end
      end
      S_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack || (cnt_q == CW'(MAX_WAIT - 1))) begin
          state_d = S_RESP;
        end
      end
`endif
      S_RESP: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Transaction context, wait counter and response capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ea_q       <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      store_q    <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= ERR_OK;
    end else if (accept) begin
      ea_q       <= ea_next;
      size_q     <= dec_size;
      signed_q   <= dec_signed;
      store_q    <= dec_store;
      wdata_q    <= dec_store ? wdata_rep : '0;
      wstrb_q    <= dec_store ? wstrb_next : '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= dec_err;
    end else if (mem_req) begin
      if (mem_ack) begin
        cnt_q <= '0;
        if (!store_q) begin
          rsp_data_q <= load_ext;
        end
`ifdef LSU_RMW_EN
        if (state_q == S_RD) begin
          wdata_q <= merged;
          wstrb_q <= '1;
        end
`endif
      end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
        cnt_q     <= '0;
        rsp_err_q <= ERR_TMO;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign mem_addr  = mem_req ? {ea_q[XLEN-1:OW], {OW{1'b0}}} : '0;
  assign mem_wdata = (mem_req && mem_we) ? wdata_q : '0;
  assign mem_wstrb = (mem_req && mem_we) ? wstrb_q : '0;
  assign rsp_data  = rsp_valid ? rsp_data_q : '0;
  assign rsp_err   = rsp_valid ? rsp_err_q : ERR_OK;
  assign rf_wr_en  = rsp_valid && !store_q && (rsp_err_q == ERR_OK);

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl at XLEN=32, MAX_WAIT=15.
module tb_lsu_ctrl;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  err;
    logic        wr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_base = '0;
  logic [31:0] req_imm = '0;
  logic [31:0] req_wdata = '0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  logic        rf_wr_en;

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t exp_q[$];

  lsu_ctrl #(.XLEN(32), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_base(req_base), .req_imm(req_imm), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rf_wr_en(rf_wr_en)
  );

  always #5 clk = ~clk;

  // Reference load extraction for the 32-bit datapath
  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [1:0] lane,
                                             input logic [31:0] rd);
    logic [31:0] s;
    s = rd >> (8 * lane);
    case (op)
      4'd0:    return {{24{s[7]}}, s[7:0]};
      4'd3:    return {24'h0, s[7:0]};
      4'd1:    return {{16{s[15]}}, s[15:0]};
      4'd4:    return {16'h0, s[15:0]};
      default: return s;
    endcase
  endfunction

  // Response monitor: every rsp_valid pulse must match the oldest expected response
  always @(negedge clk) begin
    if (rst && rsp_valid) begin
      exp_t e;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_rsp: got data=%h err=%0d wr=%b, required no response",
                 rsp_data, rsp_err, rf_wr_en);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_data, rsp_err, rf_wr_en} !== {e.data, e.err, e.wr}) begin
          tests_failed++;
          $display("[TB] FAIL rsp: got data=%h err=%0d wr=%b, required data=%h err=%0d wr=%b",
                   rsp_data, rsp_err, rf_wr_en, e.data, e.err, e.wr);
        end
      end
    end
  end

  // Present a request and hold it until the DUT accepts; returns #1 into cycle T+1
  task automatic send_req(input logic [3:0] op, input logic [31:0] base, input logic [31:0] imm,
                          input logic [31:0] wdata);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_base  = base;
    req_imm   = imm;
    req_wdata = wdata;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL accept_timeout: req_ready=%b, required 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    tests_run++;
    if ({req_ready, mem_req, mem_we, rsp_valid, rf_wr_en} !== 5'b10000) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: got rdy/req/we/vld/wr=%b, required 10000",
               {req_ready, mem_req, mem_we, rsp_valid, rf_wr_en});
    end
    tests_run++;
    if ({mem_addr, mem_wdata, mem_wstrb, rsp_data, rsp_err} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: got addr=%h wdata=%h strb=%b data=%h err=%0d, required 0",
               mem_addr, mem_wdata, mem_wstrb, rsp_data, rsp_err);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_word();
    exp_q.push_back('{data: 32'hDEADBEEF, err: 2'd0, wr: 1'b1});
    send_req(4'd2, 32'h100, 32'h4, 32'h0);
    tests_run++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h104}) begin
      tests_failed++;
      $display("[TB] FAIL lw_mem: got req=%b we=%b addr=%h, required 1 0 00000104",
               mem_req, mem_we, mem_addr);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    tests_run++;
    if ({rsp_valid, mem_req} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL lw_rsp_t2: got vld=%b req=%b, required 1 0", rsp_valid, mem_req);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL lw_ready_t3: got rdy=%b vld=%b, required 1 0", req_ready, rsp_valid);
    end
    exp_q.push_back('{data: 32'hCAFE0001, err: 2'd0, wr: 1'b1});
    send_req(4'd2, 32'hFFFF_FFFC, 32'h8, 32'h0);
    tests_run++;
    if (mem_addr !== 32'h4) begin
      tests_failed++;
      $display("[TB] FAIL ea_wrap: got addr=%h, required 00000004", mem_addr);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFE0001;
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  task automatic test_load_lanes();
    logic [3:0] ops[5];
    logic [1:0] lane;
    logic [31:0] rd;
    ops = '{4'd0, 4'd3, 4'd1, 4'd4, 4'd2};
    exp_q.push_back('{data: 32'hFFFFFF80, err: 2'd0, wr: 1'b1});
    send_req(4'd0, 32'h100, 32'h3, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h8000_0000;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    exp_q.push_back('{data: 32'h00000080, err: 2'd0, wr: 1'b1});
    send_req(4'd3, 32'h100, 32'h3, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h8000_0000;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    for (int i = 0; i < 15; i++) begin
      logic [3:0] op;
      op = ops[i % 5];
      lane = 2'($urandom_range(0, 3));
      if (op == 4'd1 || op == 4'd4) lane[0] = 1'b0;
      if (op == 4'd2) lane = 2'd0;
      rd = $urandom;
      if (i < 5) rd[31] = 1'b1;
      exp_q.push_back('{data: model_load(op, lane, rd), err: 2'd0, wr: 1'b1});
      send_req(op, 32'h400, {30'h0, lane}, 32'h0);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
      mem_ack = 1'b1; mem_rdata = rd;
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
  endtask

  task automatic test_store();
`ifdef LSU_RMW_EN
    exp_q.push_back('{data: 32'h0, err: 2'd0, wr: 1'b0});
    send_req(4'd9, 32'h100, 32'h2, 32'h1234ABCD);
    tests_run++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
      tests_failed++;
      $display("[TB] FAIL rmw_rd: got req=%b we=%b addr=%h, required 1 0 00000100",
               mem_req, mem_we, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h11223344;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    tests_run++;
    if ({mem_req, mem_we, mem_wdata, mem_wstrb} !== {1'b1, 1'b1, 32'hABCD3344, 4'b1111}) begin
      tests_failed++;
      $display("[TB] FAIL rmw_wr: got req=%b we=%b wdata=%h strb=%b, required 1 1 abcd3344 1111",
               mem_req, mem_we, mem_wdata, mem_wstrb);
    end
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
`else
    exp_q.push_back('{data: 32'h0, err: 2'd0, wr: 1'b0});
    send_req(4'd9, 32'h100, 32'h2, 32'h1234ABCD);
    tests_run++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !==
        {1'b1, 1'b1, 32'h100, 32'hABCDABCD, 4'b1100}) begin
      tests_failed++;
      $display("[TB] FAIL sh_mem: got req=%b we=%b addr=%h wdata=%h strb=%b, required 1 1 00000100 abcdabcd 1100",
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb);
    end
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    exp_q.push_back('{data: 32'h0, err: 2'd0, wr: 1'b0});
    send_req(4'd8, 32'h100, 32'h1, 32'hFFFF_FF55);
    tests_run++;
    if ({mem_wdata, mem_wstrb} !== {32'h55555555, 4'b0010}) begin
      tests_failed++;
      $display("[TB] FAIL sb_mem: got wdata=%h strb=%b, required 55555555 0010", mem_wdata, mem_wstrb);
    end
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
`endif
    exp_q.push_back('{data: 32'h0, err: 2'd0, wr: 1'b0});
    send_req(4'd10, 32'h1F0, 32'h10, 32'hCAFEF00D);
    for (int c = 0; c < 3; c++) begin
      tests_run++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !==
          {1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 4'b1111}) begin
        tests_failed++;
        $display("[TB] FAIL sw_hold%0d: got req=%b we=%b addr=%h wdata=%h strb=%b, required 1 1 00000200 cafef00d 1111",
                 c, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb);
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  task automatic test_errors();
    logic [3:0]  ops[8];
    logic [31:0] imms[8];
    logic [1:0]  errs[8];
    ops  = '{4'd2, 4'd9, 4'd1, 4'd7, 4'd5, 4'd6, 4'd11, 4'd12};
    imms = '{32'h1, 32'h3, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h2};
    errs = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{data: 32'h0, err: errs[i], wr: 1'b0});
      send_req(ops[i], 32'h100, imms[i], 32'h12345678);
      tests_run++;
      if ({rsp_valid, mem_req} !== 2'b10) begin
        tests_failed++;
        $display("[TB] FAIL err_t1_%0d: got vld=%b req=%b, required 1 0", i, rsp_valid, mem_req);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    exp_q.push_back('{data: 32'h0, err: 2'd2, wr: 1'b0});
    send_req(4'd10, 32'h300, 32'h0, 32'h0BADF00D);
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (n !== 15) begin
      tests_failed++;
      $display("[TB] FAIL timeout_len: got %0d mem_req cycles, required 15", n);
    end
    tests_run++;
    if (rsp_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_rsp: got vld=%b, required 1", rsp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    send_req(4'd10, 32'h500, 32'h0, 32'h11111111);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if ({req_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, 1'b0, 1'b0, 68'h0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid: got rdy=%b req=%b we=%b addr=%h strb=%b wdata=%h, required 1 0 0 0 0 0",
               req_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({req_ready, rsp_valid} !== 2'b10) begin
        tests_failed++;
        $display("[TB] FAIL reset_after%0d: got rdy=%b vld=%b, required 1 0", c, req_ready, rsp_valid);
      end
    end
  endtask

  task automatic test_ack_ignored();
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({mem_req, rsp_valid} !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL stray_ack%0d: got req=%b vld=%b, required 0 0", c, mem_req, rsp_valid);
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_q.push_back('{data: 32'h87654321, err: 2'd0, wr: 1'b1});
    exp_q.push_back('{data: 32'h000000A5, err: 2'd0, wr: 1'b1});
    send_req(4'd2, 32'h600, 32'h0, 32'h0);
    req_valid = 1'b1; req_op = 4'd3; req_base = 32'h700; req_imm = 32'h1;
    @(posedge clk); #1;
    tests_run++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h600}) begin
      tests_failed++;
      $display("[TB] FAIL busy_ignored: got req=%b addr=%h, required 1 00000600", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h87654321;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_ready: got rdy=%b, required 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    tests_run++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h700}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: got req=%b addr=%h, required 1 00000700", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h0000A500;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_load_word();
    test_load_lanes();
    test_store();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_ack_ignored();
    test_back_to_back();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++;
      $display("[TB] FAIL pending_rsp: got %0d responses outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
